// File: rtl/bootram_pkg.sv
// Shared types and constants for the boot RAM controller.
package bootram_pkg;
  typedef enum logic {GNT_CPU = 1'b0, GNT_LD = 1'b1} grant_t;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DATA = 2'd2} state_t;
  localparam int BOOTRAM_LANES = 4;
endpackage

// File: rtl/bootram_ctrl_if.sv
// CPU native bus plus byte-wide firmware loader port; master = requesters, slave = controller.
interface bootram_ctrl_if #(parameter int ADDR_W = 11);
  logic              mem_valid;
  logic              mem_ready;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_rdata;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W+1:0] ld_addr;
  logic              ld_we;
  logic [7:0]        ld_wdata;
  logic [7:0]        ld_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output ld_valid, ld_addr, ld_we, ld_wdata,
    input  mem_ready, mem_rdata, ld_ready, ld_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  ld_valid, ld_addr, ld_we, ld_wdata,
    output mem_ready, mem_rdata, ld_ready, ld_rdata
  );
endinterface

// File: rtl/bootram_2kx8.sv
// Single-port byte-lane RAM macro: write at the CE edge, registered read of the pre-write content.
module bootram_2kx8 #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  input  logic              oce,
  input  logic              wre,
  input  logic [ADDR_W-1:0] ad,
  input  logic [7:0]        din,
  output logic [7:0]        dout
);
  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] dout_q, dout_d;

  always_comb begin
    dout_d = dout_q;
    if (ce && oce) dout_d = mem_q[ad];
  end

  always_ff @(posedge clk) begin
    if (ce && wre) mem_q[ad] <= din;
    if (reset) dout_q <= '0;
    else       dout_q <= dout_d;
  end

  assign dout = dout_q;
endmodule

// File: rtl/bootram_rr_arb.sv
// Two-way round-robin arbiter; on contention the requester that was not granted last wins.
module bootram_rr_arb
  import bootram_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  grant_t last_grant_q, last_grant_d;

  always_ff @(posedge clk) begin
    if (reset) last_grant_q <= GNT_LD;
    else       last_grant_q <= last_grant_d;
  end

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = (last_grant_q == GNT_LD) ? 2'b01 : 2'b10;
    last_grant_d = last_grant_q;
    if (advance && (gnt != 2'b00)) last_grant_d = gnt[1] ? GNT_LD : GNT_CPU;
  end
endmodule

// File: rtl/bootram_ctrl.sv
// Boot RAM controller: arbitrates CPU and loader onto four byte-lane macros, IDLE -> ACCESS -> DATA.
module bootram_ctrl
  import bootram_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int LOADER_EN = 1
) (
  input  logic           clk,
  input  logic           reset,
  bootram_ctrl_if.slave  bus
);
  state_t                     state_q, state_d;
  grant_t                     grant_q, grant_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [BOOTRAM_LANES-1:0]   wre_q, wre_d;
  logic [8*BOOTRAM_LANES-1:0] wdata_q, wdata_d;
  logic [1:0]                 lane_q, lane_d;
  logic [1:0]                 req, gnt;
  logic                       ce, mem_ready, ld_ready;
  logic [7:0]                 dout [BOOTRAM_LANES];
  logic                       unused_addr_bits;

  // Upper CPU address bits are dropped, so the RAM aliases every 8 KB.
  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};
  assign req = {bus.ld_valid && (LOADER_EN != 0), bus.mem_valid};

  bootram_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .advance (state_q == IDLE),
    .gnt     (gnt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= GNT_CPU;
      addr_q  <= '0;
      wre_q   <= '0;
      wdata_q <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wre_q   <= wre_d;
      wdata_q <= wdata_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wre_d   = wre_q;
    wdata_d = wdata_q;
    lane_d  = lane_q;
    case (state_q)
      IDLE: begin
        if (gnt[0]) begin
          state_d = ACCESS;
          grant_d = GNT_CPU;
          addr_d  = bus.mem_addr[ADDR_W+1:2];
          wre_d   = bus.mem_wstrb;
          wdata_d = bus.mem_wdata;
        end else if (gnt[1]) begin
          state_d = ACCESS;
          grant_d = GNT_LD;
          addr_d  = bus.ld_addr[ADDR_W+1:2];
          wre_d   = bus.ld_we ? (BOOTRAM_LANES'(1) << bus.ld_addr[1:0]) : '0;
          wdata_d = {BOOTRAM_LANES{bus.ld_wdata}};
          lane_d  = bus.ld_addr[1:0];
        end
      end
      ACCESS:  state_d = DATA;
      DATA:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by reset so a reset landing in DATA swallows the pulse.
  always_comb begin
    ce            = (state_q == ACCESS);
    mem_ready     = (state_q == DATA) && (grant_q == GNT_CPU) && !reset;
    ld_ready      = (state_q == DATA) && (grant_q == GNT_LD) && !reset && (LOADER_EN != 0);
    bus.mem_ready = mem_ready;
    bus.ld_ready  = ld_ready;
    bus.mem_rdata = mem_ready ? {dout[3], dout[2], dout[1], dout[0]} : '0;
    bus.ld_rdata  = ld_ready ? dout[lane_q] : '0;
  end

  bootram_2kx8 #(.ADDR_W(ADDR_W)) bootram_2kx8_0 (
    .clk(clk), .reset(reset), .ce(ce), .oce(1'b1), .wre(wre_q[0]),
    .ad(addr_q), .din(wdata_q[7:0]), .dout(dout[0])
  );
  bootram_2kx8 #(.ADDR_W(ADDR_W)) bootram_2kx8_1 (
    .clk(clk), .reset(reset), .ce(ce), .oce(1'b1), .wre(wre_q[1]),
    .ad(addr_q), .din(wdata_q[15:8]), .dout(dout[1])
  );
  bootram_2kx8 #(.ADDR_W(ADDR_W)) bootram_2kx8_2 (
    .clk(clk), .reset(reset), .ce(ce), .oce(1'b1), .wre(wre_q[2]),
    .ad(addr_q), .din(wdata_q[23:16]), .dout(dout[2])
  );
  bootram_2kx8 #(.ADDR_W(ADDR_W)) bootram_2kx8_3 (
    .clk(clk), .reset(reset), .ce(ce), .oce(1'b1), .wre(wre_q[3]),
    .ad(addr_q), .din(wdata_q[31:24]), .dout(dout[3])
  );
endmodule

// File: tb/tb_bootram_ctrl.sv
// Directed bench for bootram_ctrl: data path, latency, arbitration, aliasing, reset and loader disable.
module tb_bootram_ctrl;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  bootram_ctrl_if #(.ADDR_W(11)) bus ();
  bootram_ctrl_if #(.ADDR_W(11)) bus2 ();

  bootram_ctrl #(.ADDR_W(11), .LOADER_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bootram_ctrl #(.ADDR_W(11), .LOADER_EN(0)) dut_nold (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle; returns at posedge+1 back in IDLE.
  task automatic cpu_op(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output int lat);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_wstrb = strb;
    bus.mem_valid = 1'b1;
    lat   = 0;
    rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        lat   = c + 1;
        rdata = bus.mem_rdata;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    @(posedge clk); #1;
    chk("cpu_ready_width", 32'(bus.mem_ready), 32'd0);
  endtask

  task automatic ld_op(input logic [12:0] addr, input logic we, input logic [7:0] wdata,
                       output logic [7:0] rdata, output int lat);
    bus.ld_addr  = addr;
    bus.ld_we    = we;
    bus.ld_wdata = wdata;
    bus.ld_valid = 1'b1;
    lat   = 0;
    rdata = '0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (bus.ld_ready) begin
        lat   = c + 1;
        rdata = bus.ld_rdata;
        break;
      end
    end
    bus.ld_valid = 1'b0;
    @(posedge clk); #1;
    chk("ld_ready_width", 32'(bus.ld_ready), 32'd0);
  endtask

  logic [31:0] rd;
  logic [7:0]  rb;
  int          lat;
  int          n;
  int          ncpu;
  int          who [8];
  int          tim [8];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_we     = 1'b0; bus.ld_wdata = '0;
    bus2.mem_valid = 1'b0; bus2.mem_addr = '0; bus2.mem_wdata = '0; bus2.mem_wstrb = '0;
    bus2.ld_valid  = 1'b0; bus2.ld_addr  = '0; bus2.ld_we     = 1'b0; bus2.ld_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
    chk("rst_ld_ready",  32'(bus.ld_ready),  32'd0);
    chk("rst_mem_rdata", bus.mem_rdata,      32'd0);
    chk("rst_ld_rdata",  32'(bus.ld_rdata),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Full-word write then read back
    cpu_op(32'h10, 32'hDEADBEEF, 4'hF, rd, lat);
    chk("wr_full_latency", 32'(lat), 32'd3);
    cpu_op(32'h10, 32'h0, 4'h0, rd, lat);
    chk("rd_full_latency", 32'(lat), 32'd3);
    chk("rd_full_data", rd, 32'hDEADBEEF);

    // Single byte strobe; the write returns the pre-write word
    cpu_op(32'h10, 32'h0000AA00, 4'h2, rd, lat);
    chk("wr_strb_prewrite", rd, 32'hDEADBEEF);
    cpu_op(32'h10, 32'h0, 4'h0, rd, lat);
    chk("rd_strb_data", rd, 32'hDEADAAEF);

    // Loader write to lane 3, CPU sees it, loader reads lane 1
    ld_op(13'h013, 1'b1, 8'h5A, rb, lat);
    chk("ld_wr_latency", 32'(lat), 32'd3);
    chk("ld_wr_prewrite", 32'(rb), 32'h000000DE);
    cpu_op(32'h10, 32'h0, 4'h0, rd, lat);
    chk("rd_after_ld", rd, 32'h5AADAAEF);
    ld_op(13'h011, 1'b0, 8'h00, rb, lat);
    chk("ld_rd_lane1", 32'(rb), 32'h000000AA);

    // Address alias across 8 KB
    cpu_op(32'h2010, 32'h0, 4'h0, rd, lat);
    chk("alias_2010", rd, 32'h5AADAAEF);

    // Sustained contention after reset
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_addr = 32'h10; bus.mem_wstrb = 4'h0; bus.mem_valid = 1'b1;
    bus.ld_addr = 13'h013; bus.ld_we = 1'b0; bus.ld_valid = 1'b1;
    n = 0;
    ncpu = 0;
    for (int i = 0; i < 8; i++) begin
      who[i] = -1;
      tim[i] = -1;
    end
    for (int c = 1; c <= 40 && n < 8; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ready || bus.ld_ready) begin
        chk("cont_one_ready", 32'(bus.mem_ready && bus.ld_ready), 32'd0);
        who[n] = bus.ld_ready ? 1 : 0;
        tim[n] = c + 1;
        if (bus.mem_ready) begin
          ncpu++;
          chk("cont_cpu_data", bus.mem_rdata, 32'h5AADAAEF);
        end else begin
          chk("cont_ld_data", 32'(bus.ld_rdata), 32'h0000005A);
        end
        n++;
      end
    end
    bus.mem_valid = 1'b0;
    bus.ld_valid  = 1'b0;
    @(posedge clk); #1;
    chk("cont_grant_count", 32'(n), 32'd8);
    chk("cont_cpu_count", 32'(ncpu), 32'd4);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("cont_who_%0d", i), 32'(who[i]), 32'(i % 2));
      chk($sformatf("cont_time_%0d", i), 32'(tim[i]), 32'(3 + 3 * i));
    end

    // Reset during DATA swallows the ready pulse
    bus.mem_addr = 32'h10; bus.mem_wstrb = 4'h0; bus.mem_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("rst_data_no_ready", 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.mem_valid = 1'b0;
    chk("rst_data_after", 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_data_after2", 32'(bus.mem_ready), 32'd0);
    cpu_op(32'h10, 32'h0, 4'h0, rd, lat);
    chk("post_rst_latency", 32'(lat), 32'd3);
    chk("post_rst_data", rd, 32'h5AADAAEF);

    // Loader disabled: loader requests are ignored, CPU served every 3 cycles
    bus2.mem_addr = 32'h0; bus2.mem_wstrb = 4'h0; bus2.mem_valid = 1'b1;
    bus2.ld_addr = 13'h001; bus2.ld_we = 1'b1; bus2.ld_wdata = 8'h77; bus2.ld_valid = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("nold_ld_ready_c%0d", c + 1), 32'(bus2.ld_ready), 32'd0);
      chk($sformatf("nold_cpu_ready_c%0d", c + 1), 32'(bus2.mem_ready),
          32'(((c + 1) % 3) == 0));
    end
    chk("nold_ld_rdata", 32'(bus2.ld_rdata), 32'd0);
    bus2.mem_valid = 1'b0;
    bus2.ld_valid  = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
